// File: rtl/ysyx_23060332_wb_arb_pkg.sv
// Shared widths, write-back requester encoding and reset priority for the write-back arbiter.
package ysyx_23060332_wb_arb_pkg;

    localparam int unsigned RegAddrBus = 5;
    localparam int unsigned RegDataBus = 32;

    typedef enum logic {
        WB_EXU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;

    localparam wb_src_e WbPrioRst = WB_LSU;

endpackage

// File: rtl/ysyx_23060332_scoreboard.sv
// Register busy vector: set on hazard-free issue, cleared when the write-back reaches the
// register file; produces the IDU stall for RAW/WAW hazards.
module ysyx_23060332_scoreboard
    import ysyx_23060332_wb_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = RegAddrBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_waddr,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    output logic              stall
);

    localparam int unsigned NumRegs = 2 ** ADDR_W;

    logic [NumRegs-1:0] busy;
    logic [NumRegs-1:0] busy_eff;
    logic [NumRegs-1:0] busy_d;
    logic               hazard;

    always_comb begin
        // A register being written this cycle is already released to consumers.
        busy_eff = busy;
        if (wb_en) begin
            busy_eff[wb_addr] = 1'b0;
        end
        hazard = ((raddr1    != '0) & busy_eff[raddr1]) |
                 ((raddr2    != '0) & busy_eff[raddr2]) |
                 ((iss_waddr != '0) & busy_eff[iss_waddr]);
        stall  = hazard & rst;

        // Set after clear, so a re-issue of the releasing rd stays tracked.
        busy_d = busy_eff;
        if (iss_valid && !hazard && (iss_waddr != '0)) begin
            busy_d[iss_waddr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= busy_d;
        end
    end

endmodule

// File: rtl/ysyx_23060332_wb_arb.sv
// Round-robin EXU/LSU write-back arbiter with registered register-file write command.
// Optional register scoreboard enabled by YSYX_23060332_WB_SCOREBOARD_EN.
module ysyx_23060332_wb_arb
    import ysyx_23060332_wb_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = RegAddrBus,
    parameter int unsigned DATA_W = RegDataBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exu_valid,
    output logic              exu_ready,
    input  logic [ADDR_W-1:0] exu_waddr,
    input  logic [DATA_W-1:0] exu_wdata,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [ADDR_W-1:0] lsu_waddr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_waddr,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic              stall,
    output logic              reg_wen,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata
);

    wb_src_e prio;
    logic    exu_gnt;
    logic    lsu_gnt;

    always_comb begin
        exu_gnt   = exu_valid & (~lsu_valid | (prio == WB_EXU));
        lsu_gnt   = lsu_valid & (~exu_valid | (prio == WB_LSU));
        exu_ready = exu_gnt & rst;
        lsu_ready = lsu_gnt & rst;
    end

    // x0 requests are consumed and rotate priority but never reach the register file.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio    <= WbPrioRst;
            reg_wen <= 1'b0;
            waddr   <= '0;
            wdata   <= '0;
        end else begin
            reg_wen <= 1'b0;
            if (lsu_gnt) begin
                prio <= WB_EXU;
                if (lsu_waddr != '0) begin
                    reg_wen <= 1'b1;
                    waddr   <= lsu_waddr;
                    wdata   <= lsu_wdata;
                end
            end else if (exu_gnt) begin
                prio <= WB_LSU;
                if (exu_waddr != '0) begin
                    reg_wen <= 1'b1;
                    waddr   <= exu_waddr;
                    wdata   <= exu_wdata;
                end
            end
        end
    end

`ifdef YSYX_23060332_WB_SCOREBOARD_EN
    ysyx_23060332_scoreboard #(
        .ADDR_W(ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .iss_valid(iss_valid),
        .iss_waddr(iss_waddr),
        .raddr1   (raddr1),
        .raddr2   (raddr2),
        .wb_en    (reg_wen),
        .wb_addr  (waddr),
        .stall    (stall)
    );
`else
    logic unused_iss;
    assign unused_iss = ^{iss_valid, iss_waddr, raddr1, raddr2};
    assign stall      = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_23060332_wb_arb.sv
// Scoreboard bench for ysyx_23060332_wb_arb: stimulus pushes expected writes, a monitor checks them.
module tb_ysyx_23060332_wb_arb;

`ifdef YSYX_23060332_WB_SCOREBOARD_EN
    localparam logic SbOn = 1'b1;
`else
    localparam logic SbOn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        exu_valid, exu_ready, lsu_valid, lsu_ready;
    logic [4:0]  exu_waddr, lsu_waddr, iss_waddr, raddr1, raddr2, waddr;
    logic [31:0] exu_wdata, lsu_wdata, wdata;
    logic        iss_valid, stall, reg_wen;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    ysyx_23060332_wb_arb dut (
        .clk      (clk),
        .rst      (rst),
        .exu_valid(exu_valid),
        .exu_ready(exu_ready),
        .exu_waddr(exu_waddr),
        .exu_wdata(exu_wdata),
        .lsu_valid(lsu_valid),
        .lsu_ready(lsu_ready),
        .lsu_waddr(lsu_waddr),
        .lsu_wdata(lsu_wdata),
        .iss_valid(iss_valid),
        .iss_waddr(iss_waddr),
        .raddr1   (raddr1),
        .raddr2   (raddr2),
        .stall    (stall),
        .reg_wen  (reg_wen),
        .waddr    (waddr),
        .wdata    (wdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every register-file write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst === 1'b1 && reg_wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got waddr=%0d wdata=%h, required no write",
                         waddr, wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wb_waddr", {27'b0, waddr}, {27'b0, e.a});
                chk("wb_wdata", wdata, e.d);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        exu_valid = 1'b1; exu_waddr = '0; exu_wdata = '0;
        lsu_valid = 1'b1; lsu_waddr = '0; lsu_wdata = '0;
        iss_valid = 1'b0; iss_waddr = '0; raddr1 = '0; raddr2 = '0;
        #2;
        chk("rst_exu_ready", exu_ready, 0);
        chk("rst_lsu_ready", lsu_ready, 0);
        chk("rst_reg_wen", reg_wen, 0);
        chk("rst_stall", stall, 0);
        exu_valid = 1'b0; lsu_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        tick();
        chk("idle_exu_ready", exu_ready, 0);
        chk("idle_lsu_ready", lsu_ready, 0);
        chk("idle_reg_wen", reg_wen, 0);
        chk("idle_stall", stall, 0);

        // Both valid from reset: LSU first, then EXU, consecutive writes.
        exu_valid = 1'b1; exu_waddr = 5'd4; exu_wdata = 32'h4444_0004;
        lsu_valid = 1'b1; lsu_waddr = 5'd3; lsu_wdata = 32'h3333_0003;
        #1;
        chk("both_lsu_ready", lsu_ready, 1);
        chk("both_exu_ready", exu_ready, 0);
        push(5'd3, 32'h3333_0003);
        tick();
        lsu_valid = 1'b0;
        #1;
        chk("both_exu_ready2", exu_ready, 1);
        chk("b2b_reg_wen1", reg_wen, 1);
        push(5'd4, 32'h4444_0004);
        tick();
        exu_valid = 1'b0;
        chk("b2b_reg_wen2", reg_wen, 1);
        tick();

        // EXU only.
        exu_valid = 1'b1; exu_waddr = 5'd5; exu_wdata = 32'h1234_5678;
        #1;
        chk("exu_only_ready", exu_ready, 1);
        push(5'd5, 32'h1234_5678);
        tick();
        exu_valid = 1'b0;

        // LSU only, then both: priority now rests on EXU.
        lsu_valid = 1'b1; lsu_waddr = 5'd11; lsu_wdata = 32'h0000_000B;
        #1;
        chk("lsu_only_ready", lsu_ready, 1);
        push(5'd11, 32'h0000_000B);
        tick();
        lsu_valid = 1'b0;
        exu_valid = 1'b1; exu_waddr = 5'd12; exu_wdata = 32'hC0C0_C0C0;
        lsu_valid = 1'b1; lsu_waddr = 5'd13; lsu_wdata = 32'hD0D0_D0D0;
        #1;
        chk("rr_exu_ready", exu_ready, 1);
        chk("rr_lsu_ready", lsu_ready, 0);
        push(5'd12, 32'hC0C0_C0C0);
        tick();
        exu_valid = 1'b0;
        #1;
        chk("rr_lsu_wait1", lsu_ready, 1);
        push(5'd13, 32'hD0D0_D0D0);
        tick();
        lsu_valid = 1'b0;

        // x0 write: accepted, no register write, priority rotates.
        exu_valid = 1'b1; exu_waddr = 5'd0; exu_wdata = 32'hFFFF_FFFF;
        iss_valid = 1'b1; iss_waddr = 5'd0;
        #1;
        chk("x0_exu_ready", exu_ready, 1);
        tick();
        exu_valid = 1'b0; iss_valid = 1'b0;
        #1;
        chk("x0_reg_wen", reg_wen, 0);
        chk("x0_stall", stall, 0);
        exu_valid = 1'b1; exu_waddr = 5'd14; exu_wdata = 32'hEEEE_000E;
        lsu_valid = 1'b1; lsu_waddr = 5'd15; lsu_wdata = 32'hFFFF_000F;
        #1;
        chk("x0_prio_lsu_ready", lsu_ready, 1);
        chk("x0_prio_exu_ready", exu_ready, 0);
        push(5'd15, 32'hFFFF_000F);
        tick();
        lsu_valid = 1'b0;
        #1;
        chk("x0_prio_exu_ready2", exu_ready, 1);
        push(5'd14, 32'hEEEE_000E);
        tick();
        exu_valid = 1'b0;

        // RAW on x7 released by an LSU write.
        iss_valid = 1'b1; iss_waddr = 5'd7;
        #1;
        chk("raw_issue_stall", stall, 0);
        tick();
        iss_valid = 1'b0; iss_waddr = 5'd0; raddr1 = 5'd7;
        #1;
        chk("raw_stall", stall, SbOn);
        tick();
        chk("raw_stall_hold", stall, SbOn);
        raddr1 = 5'd0; iss_waddr = 5'd7;
        #1;
        chk("waw_stall", stall, SbOn);
        iss_waddr = 5'd0; raddr1 = 5'd7;
        tick();
        lsu_valid = 1'b1; lsu_waddr = 5'd7; lsu_wdata = 32'h7777_7777;
        #1;
        chk("raw_lsu_ready", lsu_ready, 1);
        chk("raw_stall_pre", stall, SbOn);
        push(5'd7, 32'h7777_7777);
        tick();
        lsu_valid = 1'b0;
        #1;
        chk("raw_release", stall, 0);
        tick();
        chk("raw_release_hold", stall, 0);
        raddr1 = 5'd0;

        // Reset mid-flight discards the pending write and busy bits.
        iss_valid = 1'b1; iss_waddr = 5'd9;
        exu_valid = 1'b1; exu_waddr = 5'd10; exu_wdata = 32'h0000_000A;
        #1;
        chk("rstmid_exu_ready", exu_ready, 1);
        tick();
        iss_valid = 1'b0; iss_waddr = 5'd0; exu_valid = 1'b0; raddr2 = 5'd9;
        #1;
        chk("rstmid_stall_pre", stall, SbOn);
        chk("rstmid_pending", reg_wen, 1);
        rst = 1'b0;
        #1;
        chk("rstmid_reg_wen", reg_wen, 0);
        chk("rstmid_waddr", {27'b0, waddr}, 0);
        chk("rstmid_stall", stall, 0);
        @(negedge clk) rst = 1'b1;
        tick();
        chk("post_rst_stall", stall, 0);
        chk("post_rst_reg_wen", reg_wen, 0);
        exu_valid = 1'b1; exu_waddr = 5'd16; exu_wdata = 32'h1616_1616;
        lsu_valid = 1'b1; lsu_waddr = 5'd17; lsu_wdata = 32'h1717_1717;
        #1;
        chk("post_rst_prio_lsu", lsu_ready, 1);
        push(5'd17, 32'h1717_1717);
        tick();
        lsu_valid = 1'b0;
        #1;
        chk("post_rst_exu_ready", exu_ready, 1);
        push(5'd16, 32'h1616_1616);
        tick();
        exu_valid = 1'b0;
        raddr2 = 5'd0;
        repeat (3) tick();

        chk("drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
